// File: rtl/axil_req_arbiter_if.sv
// Bundle of client request/response signals and the AXI4-Lite master channels
// shared by the round-robin arbiter. The arbiter uses the master modport; the
// clients plus the downstream slave (or a bench) use the slave modport.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising aclk edge where both valid and ready are high; the source holds valid
// and its payload stable until that edge, and valid never depends on ready.
interface axil_req_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // client side
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0]              req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
   logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb;
   logic [NUM_REQ-1:0]              rsp_valid;
   logic [DATA_WIDTH-1:0]           rsp_data;
   logic [1:0]                      rsp_resp;
   logic                            timeout_err;

   // AXI4-Lite master side
   logic [ADDR_WIDTH-1:0]   m_awaddr;
   logic [2:0]              m_awprot;
   logic                    m_awvalid;
   logic                    m_awready;
   logic [DATA_WIDTH-1:0]   m_wdata;
   logic [DATA_WIDTH/8-1:0] m_wstrb;
   logic                    m_wvalid;
   logic                    m_wready;
   logic [1:0]              m_bresp;
   logic                    m_bvalid;
   logic                    m_bready;
   logic [ADDR_WIDTH-1:0]   m_araddr;
   logic [2:0]              m_arprot;
   logic                    m_arvalid;
   logic                    m_arready;
   logic [DATA_WIDTH-1:0]   m_rdata;
   logic [1:0]              m_rresp;
   logic                    m_rvalid;
   logic                    m_rready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, rsp_valid, rsp_data, rsp_resp, timeout_err,
      output m_awaddr, m_awprot, m_awvalid, input m_awready,
      output m_wdata, m_wstrb, m_wvalid, input m_wready,
      input  m_bresp, m_bvalid, output m_bready,
      output m_araddr, m_arprot, m_arvalid, input m_arready,
      input  m_rdata, m_rresp, m_rvalid, output m_rready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, rsp_valid, rsp_data, rsp_resp, timeout_err,
      input  m_awaddr, m_awprot, m_awvalid, output m_awready,
      input  m_wdata, m_wstrb, m_wvalid, output m_wready,
      output m_bresp, m_bvalid, input m_bready,
      input  m_araddr, m_arprot, m_arvalid, output m_arready,
      output m_rdata, m_rresp, m_rvalid, input m_rready
   );
endinterface

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port among NUM_REQ
// request/response clients. One command is in flight at a time; a sticky
// watchdog flag reports a transaction that has waited TIMEOUT cycles.
module axil_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                 aclk,
   input  logic                 areset,
   axil_req_arbiter_if.master   bus,
   output logic [2:0]           dbg_state_o
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          last_grant_q, grant_q, grant_idx;
   logic                   grant_found, accept, busy;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [SW-1:0]          wstrb_q;
   logic                   aw_pend_q, w_pend_q;
   logic [NUM_REQ-1:0]     rsp_valid_q;
   logic [DATA_WIDTH-1:0]  rsp_data_q;
   logic [1:0]             rsp_resp_q;
   logic [CW-1:0]          cnt_q;
   logic                   timeout_q;

   // Round-robin scan: first requesting client after the last one served.
   always_comb begin : p_scan
      int scan;
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan = (int'(last_grant_q) + k) % NUM_REQ;
         if (!grant_found && bus.req_valid[GW'(scan)]) begin
            grant_found = 1'b1;
            grant_idx   = GW'(scan);
         end
      end
   end

   // A command is taken only in IDLE; reset also masks the accept strobe.
   assign accept = (state_q == IDLE) && grant_found && !areset;
   assign busy   = (state_q == WADDR) || (state_q == WRESP) ||
                   (state_q == RADDR) || (state_q == RDATA);

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (accept) state_d = bus.req_write[grant_idx] ? WADDR : RADDR;
         WADDR: if ((!aw_pend_q || bus.m_awready) && (!w_pend_q || bus.m_wready))
                   state_d = WRESP;
         WRESP: if (bus.m_bvalid)  state_d = DONE;
         RADDR: if (bus.m_arready) state_d = RDATA;
         RDATA: if (bus.m_rvalid)  state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Capture the granted command; AW and W valids retire independently.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         grant_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
      end else if (accept) begin
         grant_q   <= grant_idx;
         addr_q    <= bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_q   <= bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
         wstrb_q   <= bus.req_wstrb[int'(grant_idx)*SW +: SW];
         aw_pend_q <= bus.req_write[grant_idx];
         w_pend_q  <= bus.req_write[grant_idx];
      end else begin
         if (aw_pend_q && bus.m_awready) aw_pend_q <= 1'b0;
         if (w_pend_q && bus.m_wready)   w_pend_q  <= 1'b0;
      end
   end

   // Latch B/R results, then pulse the winner's completion strobe from DONE.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_resp_q   <= '0;
         last_grant_q <= GW'(NUM_REQ - 1);
      end else begin
         rsp_valid_q <= '0;
         if (state_q == WRESP && bus.m_bvalid) begin
            rsp_data_q <= '0;
            rsp_resp_q <= bus.m_bresp;
         end
         if (state_q == RDATA && bus.m_rvalid) begin
            rsp_data_q <= bus.m_rdata;
            rsp_resp_q <= bus.m_rresp;
         end
         if (state_q == DONE) begin
            rsp_valid_q  <= NUM_REQ'(1) << grant_q;
            last_grant_q <= grant_q;
         end
      end
   end

   // Watchdog: counts busy cycles since accept, saturates, flag is sticky.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (TIMEOUT != 0 && busy && cnt_q != CW'(TIMEOUT)) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q + 1'b1 == CW'(TIMEOUT)) timeout_q <= 1'b1;
      end
   end

   assign bus.req_ready   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_resp    = rsp_resp_q;
   assign bus.timeout_err = timeout_q;

   assign bus.m_awaddr  = addr_q;
   assign bus.m_awprot  = 3'b000;
   assign bus.m_awvalid = aw_pend_q;
   assign bus.m_wdata   = wdata_q;
   assign bus.m_wstrb   = wstrb_q;
   assign bus.m_wvalid  = w_pend_q;
   assign bus.m_bready  = (state_q == WRESP);
   assign bus.m_araddr  = addr_q;
   assign bus.m_arprot  = 3'b000;
   assign bus.m_arvalid = (state_q == RADDR);
   assign bus.m_rready  = (state_q == RDATA);

   assign dbg_state_o = state_q;

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AXI4-Lite master port among NUM_REQ simple request/response clients. It sits between internal control clients and the AXI interconnect/VIP slave path of the chip. It accepts one client command at a time, drives the matching AXI4-Lite write (AW+W+B) or read (AR+R) sequence, and returns the response to the granted client. A watchdog counter flags a hung transaction.

Parameters:
NUM_REQ, 4, number of clients (2..8)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64)
TIMEOUT, 256, cycles from accept to B/R before timeout_err sets; 0 disables the watchdog

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-client request; held until req_ready
req_ready  out  NUM_REQ  one-hot accept strobe
req_write  in  NUM_REQ  1=write, 0=read, per client
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion strobe
rsp_data  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP/RRESP of the completed transaction
timeout_err  out  1  sticky watchdog flag
m_awaddr/m_awprot/m_awvalid  out  ADDR_WIDTH/3/1  AW channel; awprot=3'b000
m_awready  in  1
m_wdata/m_wstrb/m_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  W channel
m_wready  in  1
m_bresp/m_bvalid  in  2/1  B channel
m_bready  out  1
m_araddr/m_arprot/m_arvalid  out  ADDR_WIDTH/3/1  AR channel; arprot=3'b000
m_arready  in  1
m_rdata/m_rresp/m_rvalid  in  DATA_WIDTH/2/1  R channel
m_rready  out  1

Behaviour:
- Reset: state=IDLE; all m_*valid, m_bready, m_rready, req_ready, rsp_valid, timeout_err = 0; rsp_data, rsp_resp, m_* payloads = 0; last_grant = NUM_REQ-1 so client 0 wins first. Reset mid-transaction abandons the AXI transfer immediately. The downstream slave is reset concurrently.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE: grant g is the first set req_valid scanning from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[g] is combinational, high only in IDLE. On that edge the block latches addr/wdata/wstrb/write for g and moves to WADDR (write) or RADDR (read). Non-granted clients keep waiting.
- WADDR: m_awvalid and m_wvalid both assert the cycle after accept. Each drops independently after its own handshake, and no valid ever drops before its handshake. When both handshakes have completed (same or different cycles), go to WRESP.
- WRESP: m_bready=1. On m_bvalid, latch bresp, set rsp_data=0, go to DONE.
- RADDR: m_arvalid=1 until m_arready, then RDATA.
- RDATA: m_rready=1. On m_rvalid, latch rdata/rresp, go to DONE.
- DONE: rsp_valid[g]=1 for exactly one cycle; last_grant<=g; go to IDLE.
- rsp_data/rsp_resp hold their value until the next DONE.
- Minimum latency with always-ready slave and same-cycle B/R: accept edge to rsp_valid is 3 cycles for both write and read. Back-to-back accepts are separated by at least 4 cycles. Only one transaction is outstanding.
- Watchdog: counter clears on accept and increments each cycle in WADDR/WRESP/RADDR/RDATA, saturating at TIMEOUT. At count==TIMEOUT, timeout_err sets and stays set until reset. The transaction is never aborted; the FSM keeps waiting.
- A req_valid withdrawn before req_ready is a client protocol violation; behaviour is unspecified.

Test Plan:
1. Client 0 write, addr 0x10, data 0xDEADBEEF, wstrb 0xF, slave always ready, B next cycle -> one AW and one W handshake carrying those values; rsp_valid[0] for 1 cycle with rsp_resp=00 and rsp_data=0.
2. Client 2 read, addr 0x44, slave returns rdata 0x12345678 with rresp 00 -> m_araddr=0x44; rsp_valid=4'b0100, rsp_data=0x12345678.
3. All four req_valid held continuously -> grant order 0,1,2,3,0,1; no client is granted twice before the others.
4. m_awready delayed 3 cycles, m_wready immediate -> m_wvalid high 1 cycle, m_awvalid high 4 cycles; WRESP entered only after AW completes.
5. TIMEOUT=16, B withheld 40 cycles then bresp=10 -> timeout_err rises 16 cycles after accept and stays set; completion still returns rsp_resp=10.
6. areset pulsed while in RDATA -> all outputs go to 0 asynchronously; after release, a simultaneous req on clients 1 and 3 grants client 1 first.
